tlc_phase_sequencer: RTL and testbench
======================================

# tlc_phase_sequencer

Parametrised multi-phase traffic-light sequencer, successor to the fixed six-state two-road controller. Cycles NUM_PHASES approach groups through green → yellow → all-red clearance, with per-phase green times supplied at run time and durations counted in `tick` enables rather than raw clocks. Adds a night/fault flashing-yellow mode and an optional pedestrian walk phase. Sits between the timebase divider (which produces `tick`) and the lamp-driver outputs.

## Interface
- NUM_PHASES, 4: approach groups sequenced, 2..8
- CNT_W, 8: duration counter width
- YELLOW_TICKS, 2: yellow duration in ticks, ≥1, < 2^CNT_W
- ALLRED_TICKS, 1: all-red clearance in ticks, ≥1, < 2^CNT_W
- PED_TICKS, 6: walk duration in ticks, ≥1, < 2^CNT_W; used only with TLC_PED_EN
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- tick  in  1  one-cycle timebase enable
- en  in  1  run enable; when low, ticks are ignored and all state is frozen
- green_ticks  in  NUM_PHASES*CNT_W  green duration for phase p, in slice [p*CNT_W +: CNT_W]
- flash_mode  in  1  request flashing-yellow mode (level)
- ped_req  in  1  pedestrian request pulse
- light  out  NUM_PHASES*3  per phase {red,yellow,green}: 100 red, 010 yellow, 001 green, 000 dark
- phase_idx  out  $clog2(NUM_PHASES)  current/most recent phase
- cycle_start  out  1  one-cycle pulse on entry to phase 0 green
- walk  out  1  pedestrian walk lamp

## Operation
- States: GREEN, YELLOW, ALLRED, FLASH, WALK (WALK exists only with the macro).
- A step occurs on a clk edge with tick=1 and en=1. Counter `cnt` is loaded with duration−1 on state entry and decrements on each step; state is left on the step where cnt==0. Each state therefore lasts exactly its duration in ticks.
- GREEN(p): duration green_ticks[p], sampled on entry. Value 0 is treated as 1. Phase p shows 001 and all other phases show 100.
- YELLOW(p): duration YELLOW_TICKS. Phase p shows 010 and all others show 100.
- ALLRED: duration ALLRED_TICKS; all phases show 100. Exit priority, highest first:
  - flash_mode=1 → FLASH
  - ped_pending → WALK
  - otherwise GREEN((phase_idx+1) mod NUM_PHASES); wraps from NUM_PHASES−1 to 0
- flash_mode=1 seen on a step while in GREEN aborts green immediately into YELLOW(p). Yellow and all-red are never shortened.
- FLASH: a blink bit toggles every step. All phases show 010 when blink=1 and 000 when blink=0; blink=1 on entry. On the first step with flash_mode=0, go to ALLRED (full clearance) with phase_idx retained, then continue to the next phase.
- Reset state: ALLRED, cnt=ALLRED_TICKS−1, phase_idx=NUM_PHASES−1, blink=0, ped_pending=0. Reset outputs: all light=100, walk=0, cycle_start=0. The first green after reset is phase 0.
- Reset asserted mid-operation takes effect immediately (asynchronous): all lights go to 100.

## Timing
- All state is registered. light, walk and phase_idx are decoded from registered state and update on the same edge as the state change, with no extra latency.
- cycle_start is registered and high for the single cycle following the edge that enters GREEN(0).
- Full cycle with no flash and no walk = Σ(max(green_ticks[p],1) + YELLOW_TICKS + ALLRED_TICKS) ticks.
- en=0 freezes cnt, state and blink regardless of tick. ped_req is still latched while en=0.

## Configuration
- TLC_PED_EN defined:
  - ped_req sets ped_pending on any cycle; set wins over a clear in the same cycle.
  - WALK lasts PED_TICKS steps with all vehicle lights 100 and walk=1. ped_pending clears on WALK entry.
  - WALK exits to GREEN(next phase).
  - flash_mode is not checked inside WALK; it takes effect at the next GREEN.
- TLC_PED_EN undefined: ports remain, ped_req is ignored, walk is tied 0, and the WALK state and ped_pending are not generated.

## Structure
- Package tlc_pkg holds the state enum, the lamp encodings (LAMP_RED=3'b100, LAMP_YEL=3'b010, LAMP_GRN=3'b001, LAMP_OFF=3'b000) and parameter-range checks.
- One sub-module, tlc_lamp_decode: combinational map from {state, phase_idx, blink} to the light vector.

## Test plan
Setup: NUM_PHASES=3, CNT_W=4, YELLOW=2, ALLRED=1, PED=3, green={3,5,4}, tick every cycle, en=1.
- Release reset → light all 100, phase_idx=2. After 1 tick, phase 0 shows 001 and cycle_start pulses. Green holds exactly 3 ticks, then yellow for 2.
- Free run → cycle_start period is 21 ticks, and phase_idx wraps 2→0.
- green[1]=0 → phase 1 green lasts 1 tick.
- Assert flash_mode mid phase-1 green:
  - next tick goes to yellow for 2 ticks, then all-red for 1
  - then FLASH: all lights alternate 010/000 each tick
  - deassert flash_mode → all-red for 1 tick, then phase 2 shows 001
- en=0 for 10 cycles with tick toggling → light, phase_idx and cnt are unchanged.
- With TLC_PED_EN: ped_req pulse during phase 0 green → after phase 0 all-red, walk=1 for 3 ticks with all lights 100, then phase 1 green. Assert rst mid-yellow → all lights 100 immediately.

Source files
------------

// File: rtl/tlc_pkg.sv
// Shared types, lamp encodings and parameter checks for the phase sequencer.
// The WALK state exists only when TLC_PED_EN is defined.
package tlc_pkg;

   typedef enum logic [2:0] {
      StGreen,
      StYellow,
      StAllred,
`ifdef TLC_PED_EN
      StWalk,
`endif
      StFlash
   } tlc_state_e;

   localparam logic [2:0] LAMP_RED = 3'b100;
   localparam logic [2:0] LAMP_YEL = 3'b010;
   localparam logic [2:0] LAMP_GRN = 3'b001;
   localparam logic [2:0] LAMP_OFF = 3'b000;

   function automatic bit tlc_params_ok(int unsigned num_phases, int unsigned cnt_w,
                                        int unsigned yel, int unsigned allred,
                                        int unsigned ped);
      longint unsigned lim;
      lim = longint'(1) << cnt_w;
      return (num_phases >= 2) && (num_phases <= 8) && (cnt_w >= 1) && (cnt_w <= 31) &&
             (yel >= 1) && (yel < lim) && (allred >= 1) && (allred < lim) &&
             (ped >= 1) && (ped < lim);
   endfunction

endpackage

// File: rtl/tlc_lamp_decode.sv
// Combinational lamp decode: {state, phase_idx, blink} -> per-phase {red,yellow,green}.
module tlc_lamp_decode
   import tlc_pkg::*;
#(
   parameter int unsigned NUM_PHASES = 4
) (
   input  tlc_state_e                      state,
   input  logic [$clog2(NUM_PHASES)-1:0]   phase_idx,
   input  logic                            blink,
   output logic [NUM_PHASES*3-1:0]         light
);

   localparam int unsigned PW = $clog2(NUM_PHASES);

   always_comb begin
      light = {NUM_PHASES{LAMP_RED}};
      for (int p = 0; p < NUM_PHASES; p++) begin
         case (state)
            StGreen:  if (phase_idx == PW'(p)) light[p*3 +: 3] = LAMP_GRN;
            StYellow: if (phase_idx == PW'(p)) light[p*3 +: 3] = LAMP_YEL;
            StFlash:  light[p*3 +: 3] = blink ? LAMP_YEL : LAMP_OFF;
            default:  light[p*3 +: 3] = LAMP_RED;
         endcase
      end
   end

endmodule

// File: rtl/tlc_phase_sequencer.sv
// Multi-phase traffic-light sequencer: green -> yellow -> all-red per phase, flashing-yellow
// mode, and an optional pedestrian walk phase enabled by the TLC_PED_EN macro.
module tlc_phase_sequencer
   import tlc_pkg::*;
#(
   parameter int unsigned NUM_PHASES   = 4,
   parameter int unsigned CNT_W        = 8,
   parameter int unsigned YELLOW_TICKS = 2,
   parameter int unsigned ALLRED_TICKS = 1,
   parameter int unsigned PED_TICKS    = 6
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            tick,
   input  logic                            en,
   input  logic [NUM_PHASES*CNT_W-1:0]     green_ticks,
   input  logic                            flash_mode,
   input  logic                            ped_req,
   output logic [NUM_PHASES*3-1:0]         light,
   output logic [$clog2(NUM_PHASES)-1:0]   phase_idx,
   output logic                            cycle_start,
   output logic                            walk
);

   localparam int unsigned PW = $clog2(NUM_PHASES);
   localparam logic [CNT_W-1:0] YEL_LOAD = CNT_W'(YELLOW_TICKS - 1);
   localparam logic [CNT_W-1:0] AR_LOAD  = CNT_W'(ALLRED_TICKS - 1);

   if (!tlc_params_ok(NUM_PHASES, CNT_W, YELLOW_TICKS, ALLRED_TICKS, PED_TICKS)) begin : g_bad
      $error("tlc_phase_sequencer: parameter out of range");
   end

   tlc_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [PW-1:0]    phase_q, phase_d, phase_nxt;
   logic             blink_q, blink_d;
   logic             cs_q, cs_d;
   logic [CNT_W-1:0] green_sel, green_load;
   logic             step, go_green;

   assign step = tick & en;

   always_comb begin
      phase_nxt = (phase_q == PW'(NUM_PHASES - 1)) ? '0 : phase_q + 1'b1;
      green_sel = '0;
      for (int p = 0; p < NUM_PHASES; p++) begin
         if (phase_nxt == PW'(p)) green_sel = green_ticks[p*CNT_W +: CNT_W];
      end
      // A programmed green of zero still lasts one tick.
      green_load = (green_sel == '0) ? '0 : green_sel - 1'b1;
   end

`ifdef TLC_PED_EN
   localparam logic [CNT_W-1:0] PED_LOAD = CNT_W'(PED_TICKS - 1);
   logic ped_pending_q, ped_pending_d, ped_clr;
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      phase_d  = phase_q;
      blink_d  = blink_q;
      cs_d     = 1'b0;
      go_green = 1'b0;
`ifdef TLC_PED_EN
      ped_clr  = 1'b0;
`endif
      if (step) begin
         case (state_q)
            StGreen: begin
               if (flash_mode || cnt_q == '0) begin
                  state_d = StYellow;
                  cnt_d   = YEL_LOAD;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            StYellow: begin
               if (cnt_q == '0) begin
                  state_d = StAllred;
                  cnt_d   = AR_LOAD;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            StAllred: begin
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - 1'b1;
               end else if (flash_mode) begin
                  state_d = StFlash;
                  blink_d = 1'b1;
`ifdef TLC_PED_EN
               end else if (ped_pending_q) begin
                  state_d = StWalk;
                  cnt_d   = PED_LOAD;
                  ped_clr = 1'b1;
`endif
               end else begin
                  go_green = 1'b1;
               end
            end
            StFlash: begin
               blink_d = ~blink_q;
               if (!flash_mode) begin
                  state_d = StAllred;
                  cnt_d   = AR_LOAD;
               end
            end
`ifdef TLC_PED_EN
            StWalk: begin
               if (cnt_q == '0) go_green = 1'b1;
               else cnt_d = cnt_q - 1'b1;
            end
`endif
            default: begin
               state_d = StAllred;
               cnt_d   = AR_LOAD;
            end
         endcase
         if (go_green) begin
            state_d = StGreen;
            phase_d = phase_nxt;
            cnt_d   = green_load;
            cs_d    = (phase_nxt == '0);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StAllred;
         cnt_q   <= AR_LOAD;
         phase_q <= PW'(NUM_PHASES - 1);
         blink_q <= 1'b0;
         cs_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
         blink_q <= blink_d;
         cs_q    <= cs_d;
      end
   end

`ifdef TLC_PED_EN
   // A request arriving in the same cycle as the walk entry stays pending.
   assign ped_pending_d = (ped_pending_q & ~ped_clr) | ped_req;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) ped_pending_q <= 1'b0;
      else     ped_pending_q <= ped_pending_d;
   end

   assign walk = (state_q == StWalk);
`else
   logic unused_ped;
   assign unused_ped = ped_req;
   assign walk       = 1'b0;
`endif

   tlc_lamp_decode #(
      .NUM_PHASES (NUM_PHASES)
   ) u_decode (
      .state     (state_q),
      .phase_idx (phase_q),
      .blink     (blink_q),
      .light     (light)
   );

   assign phase_idx   = phase_q;
   assign cycle_start = cs_q;

endmodule

// File: tb/tb_tlc_phase_sequencer.sv
// Self-checking bench for tlc_phase_sequencer against a frame-queue reference model.
module tb_tlc_phase_sequencer;

   localparam int N   = 3;
   localparam int CW  = 4;
   localparam int YEL = 2;
   localparam int AR  = 1;
   localparam int PED = 3;
`ifdef TLC_PED_EN
   localparam bit PED_ON = 1'b1;
`else
   localparam bit PED_ON = 1'b0;
`endif

   localparam int K_GRN = 0, K_YEL = 1, K_RED = 2, K_FLS = 3, K_WLK = 4;

   typedef struct {
      int kind;
      int ph;
      bit blink;
      bit first;
   } frame_t;

   logic           clk = 1'b0;
   logic           rst, tick, en, flash_mode, ped_req;
   logic [CW-1:0]  green [N];
   logic [N*CW-1:0] green_bus;
   logic [N*3-1:0] light;
   logic [1:0]     phase_idx;
   logic           cycle_start, walk;

   int checks = 0;
   int failures = 0;

   frame_t q[$];
   frame_t cur;
   bit     m_ped;
   bit     exp_cs;

   always #5 clk = ~clk;

   always_comb begin
      for (int p = 0; p < N; p++) green_bus[p*CW +: CW] = green[p];
   end

   tlc_phase_sequencer #(
      .NUM_PHASES   (N),
      .CNT_W        (CW),
      .YELLOW_TICKS (YEL),
      .ALLRED_TICKS (AR),
      .PED_TICKS    (PED)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .tick        (tick),
      .en          (en),
      .green_ticks (green_bus),
      .flash_mode  (flash_mode),
      .ped_req     (ped_req),
      .light       (light),
      .phase_idx   (phase_idx),
      .cycle_start (cycle_start),
      .walk        (walk)
   );

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Each frame is what the lamps show for one tick; segments are appended when the queue drains.
   task automatic push_n(int kind, int ph, int n, bit blink);
      frame_t f;
      for (int i = 0; i < n; i++) begin
         f.kind  = kind;
         f.ph    = ph;
         f.blink = blink;
         f.first = (i == 0);
         q.push_back(f);
      end
   endtask

   function automatic int gdur(int p);
      return (green[p] == 0) ? 1 : int'(green[p]);
   endfunction

   task automatic model_reset();
      q.delete();
      cur.kind  = K_RED;
      cur.ph    = N - 1;
      cur.blink = 1'b0;
      cur.first = 1'b1;
      push_n(K_RED, N - 1, AR - 1, 1'b0);
      m_ped  = 1'b0;
      exp_cs = 1'b0;
   endtask

   task automatic model_edge();
      int np;
      exp_cs = 1'b0;
      if (tick && en) begin
         if (cur.kind == K_GRN && flash_mode) q.delete();
         if (q.size() == 0) begin
            np = (cur.ph + 1) % N;
            case (cur.kind)
               K_GRN: push_n(K_YEL, cur.ph, YEL, 1'b0);
               K_YEL: push_n(K_RED, cur.ph, AR, 1'b0);
               K_RED: begin
                  if (flash_mode) push_n(K_FLS, cur.ph, 1, 1'b1);
                  else if (m_ped) begin
                     push_n(K_WLK, cur.ph, PED, 1'b0);
                     m_ped = 1'b0;
                  end else push_n(K_GRN, np, gdur(np), 1'b0);
               end
               K_FLS: begin
                  if (flash_mode) push_n(K_FLS, cur.ph, 1, ~cur.blink);
                  else push_n(K_RED, cur.ph, AR, 1'b0);
               end
               default: push_n(K_GRN, np, gdur(np), 1'b0);
            endcase
         end
         cur    = q.pop_front();
         exp_cs = (cur.kind == K_GRN) && cur.first && (cur.ph == 0);
      end
      if (PED_ON && ped_req) m_ped = 1'b1;
   endtask

   function automatic logic [N*3-1:0] exp_light(frame_t f);
      logic [N*3-1:0] l;
      for (int p = 0; p < N; p++) begin
         l[p*3 +: 3] = 3'b100;
         if (f.kind == K_GRN && f.ph == p) l[p*3 +: 3] = 3'b001;
         if (f.kind == K_YEL && f.ph == p) l[p*3 +: 3] = 3'b010;
         if (f.kind == K_FLS) l[p*3 +: 3] = f.blink ? 3'b010 : 3'b000;
      end
      return l;
   endfunction

   task automatic compare_all();
      chk("light", 32'(light), 32'(exp_light(cur)));
      chk("phase_idx", 32'(phase_idx), 32'(cur.ph));
      chk("cycle_start", 32'(cycle_start), 32'(exp_cs));
      chk("walk", 32'(walk), 32'(cur.kind == K_WLK));
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      #1 compare_all();
   endtask

   task automatic run(int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic wait_for(string tag, int kind, int ph);
      int k;
      k = 0;
      while (!(cur.kind == kind && (ph < 0 || cur.ph == ph)) && k < 200) begin
         cycle();
         k++;
      end
      chk(tag, 32'(k < 200), 32'd1);
   endtask

   initial begin
      int cs_t[$];
      rst = 1'b1; tick = 1'b0; en = 1'b1; flash_mode = 1'b0; ped_req = 1'b0;
      green[0] = 4'd3; green[1] = 4'd5; green[2] = 4'd4;
      repeat (3) @(negedge clk);
      chk("reset_light", 32'(light), 32'h124);
      chk("reset_phase", 32'(phase_idx), 32'd2);
      chk("reset_cs", 32'(cycle_start), 32'd0);
      chk("reset_walk", 32'(walk), 32'd0);
      rst = 1'b0; tick = 1'b1;
      model_reset();

      // Free run: first green, then cycle_start period of 21 ticks.
      for (int i = 0; i < 60; i++) begin
         cycle();
         if (cycle_start === 1'b1) cs_t.push_back(i);
      end
      chk("first_cs_tick", 32'(cs_t.size() > 0 ? cs_t[0] : -1), 32'd0);
      chk("cs_period", 32'(cs_t.size() > 1 ? cs_t[1] - cs_t[0] : -1), 32'd21);

      green[1] = 4'd0;
      run(25);
      green[1] = 4'd5;

      // Flash requested during phase-1 green, released after a few blinks.
      wait_for("wait_g1", K_GRN, 1);
      flash_mode = 1'b1;
      run(10);
      flash_mode = 1'b0;
      run(12);

      // Frozen while en is low even with tick toggling.
      en = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick = i[0];
         cycle();
      end
      en = 1'b1; tick = 1'b1;
      run(10);

      wait_for("wait_g0", K_GRN, 0);
      ped_req = 1'b1;
      cycle();
      ped_req = 1'b0;
      run(30);

      for (int i = 0; i < 1500; i++) begin
         tick    = ($urandom_range(0, 3) != 0);
         en      = ($urandom_range(0, 9) != 0);
         ped_req = ($urandom_range(0, 29) == 0);
         if ($urandom_range(0, 49) == 0) flash_mode = ~flash_mode;
         if ($urandom_range(0, 99) == 0) green[$urandom_range(0, N - 1)] = 4'($urandom_range(0, 15));
         cycle();
      end
      tick = 1'b1; en = 1'b1; ped_req = 1'b0; flash_mode = 1'b0;
      run(20);

      // Asynchronous reset in the middle of yellow.
      wait_for("wait_yel", K_YEL, -1);
      #1 rst = 1'b1;
      #1 chk("async_rst_light", 32'(light), 32'h124);
      chk("async_rst_phase", 32'(phase_idx), 32'd2);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_reset();
      run(30);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
